link_rx_buffer: RTL and testbench
=================================

// Module: link_rx_buffer
// PURPOSE
//  Receiving end of the inter-router ready/valid link. Buffers incoming flits from the upstream
//  router output port and generates the ready signal that upstream flow control consumes (its *ready_in).
//  One instance sits per router input port (N/E/W/S/L) ahead of routing/arbitration logic.
//  ready_out is registered; buffer slack absorbs flits already in flight when ready drops.
// PARAMETERS
//  DATA_WIDTH  32  flit width in bits
//  DEPTH       4   buffer entries; power of 2, >= READY_SLACK+1
//  READY_SLACK 1   entries reserved for in-flight flits after ready_out deasserts
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-low reset
//  valid_in   in   1                  upstream flit valid
//  data_in    in   DATA_WIDTH         upstream flit
//  ready_out  out  1                  to upstream *ready_in; 1 = may send next cycle
//  rd_en      in   1                  local consumer pops head flit
//  data_out   out  DATA_WIDTH         head flit, show-ahead
//  empty      out  1                  1 = no flit held
//  occupancy  out  $clog2(DEPTH+1)    flits currently held
//  overflow   out  1                  sticky: flit arrived with buffer full
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, occupancy=0, empty=1, ready_out=0, overflow=0,
//    data_out=0. ready_out first rises on the 1st clk edge after rst release.
//  - Write: valid_in=1 and (occupancy<DEPTH or rd_en accepted same cycle) -> store at wr_ptr,
//    wr_ptr+1 mod DEPTH. The buffer accepts valid_in independent of ready_out (slack absorbs).
//  - Read: rd_en=1 and empty=0 -> rd_ptr+1 mod DEPTH. rd_en while empty: ignored, no state change.
//  - Simultaneous write+read: occupancy unchanged; accepted even when full (pop frees the slot).
//  - Full with write, no read: flit dropped, overflow<=1 (sticky until reset), pointers unchanged.
//  - Latency: flit written at edge t -> data_out valid and empty=0 after edge t (1 cycle).
//    Empty write+read same cycle: read ignored (empty), write stored.
//  - data_out = mem[rd_ptr] (combinational from registered storage); undefined-but-stable when empty.
//  - occupancy_next = occupancy + wr_acc - rd_acc, registered; never exceeds DEPTH.
//  - ready_out <= (occupancy_next <= DEPTH-1-READY_SLACK), registered every cycle.
//    With DEPTH=4, SLACK=1: ready high for occupancy_next 0..2, low for 3..4.
//  - Pointers are $clog2(DEPTH) bits with natural wrap; full/empty derived from occupancy, not pointers.
//  - Reset mid-operation discards all held flits immediately; overflow clears.
// STRUCTURE
//  - Shared noc package: DATA_WIDTH default, port index constants (L,N,E,W,S), flit header field
//    positions (unused here but the width must match package FLIT_W).
//  - Sub-module: rx_fifo_mem (DEPTH x DATA_WIDTH register array, 1 write port, async read port).
//  - Top: pointer/occupancy counters, ready_out register, overflow flag.
// TESTING
//  1 Reset: hold rst=0 3 cycles -> ready_out=0, empty=1, occupancy=0; release -> ready_out=1 next edge.
//  2 Fill: valid_in=1 with data 0xA0..0xA3 on 4 cycles, rd_en=0 -> occupancy 1,2,3,4;
//    ready_out falls after the 3rd write; data_out=0xA0 throughout.
//  3 Overflow: from full, one more valid_in (0xA4) -> occupancy stays 4, overflow=1,
//    then rd_en x4 yields 0xA0,0xA1,0xA2,0xA3; ready_out back to 1 once occupancy_next<=2.
//  4 Full pass-through: full, valid_in=1 (0xB0) + rd_en=1 -> occupancy 4, no overflow, 0xB0 last out.
//  5 Empty corner: rd_en=1 while empty -> no change; valid_in+rd_en while empty -> occupancy 1.
//  6 Wrap + mid-reset: stream 10 flits with rd_en=1 each cycle -> order preserved across ptr wrap;
//    assert rst=0 with 2 held -> empty=1, ready_out=0 immediately (async).

Source files
------------

// File: rtl/link_rx_buffer_pkg.sv
// Shared NoC definitions: flit width, router port indices and flit header field positions.
package link_rx_buffer_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int FLIT_W         = NOC_DATA_WIDTH;

    typedef enum logic [2:0] {
        PORT_L = 3'd0,
        PORT_N = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_S = 3'd4
    } port_e;

    localparam int NUM_PORTS = 5;

    // Header layout within a flit: [31:30] type, [29:26] dest x, [25:22] dest y, rest payload.
    localparam int FLIT_TYPE_MSB = 31;
    localparam int FLIT_TYPE_LSB = 30;
    localparam int DEST_X_MSB    = 29;
    localparam int DEST_X_LSB    = 26;
    localparam int DEST_Y_MSB    = 25;
    localparam int DEST_Y_LSB    = 22;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
    endfunction

endpackage

// File: rtl/link_rx_buffer_fifo_mem.sv
// Register-array flit storage: one write port, combinational read of the addressed entry.
module rx_fifo_mem
    import link_rx_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

    // Entries are cleared on reset so the head reads as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/link_rx_buffer.sv
// Input-port receive buffer for the ready/valid router link with registered ready and in-flight slack.
module link_rx_buffer
    import link_rx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = FLIT_W,
    parameter int DEPTH       = 4,
    parameter int READY_SLACK = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        ready_out,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        empty,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_FULL      = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_READY_MAX = OCC_W'(DEPTH - 1 - READY_SLACK);

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic             empty_reg;
    logic             ready_reg;
    logic             overflow_reg;
    logic             wr_acc;
    logic             rd_acc;
    logic             drop;

    // A pop in the same cycle frees the slot, so a full buffer still accepts a write.
    always_comb begin
        rd_acc      = rd_en && !empty_reg;
        wr_acc      = valid_in && ((occ_reg != OCC_FULL) || rd_acc);
        drop        = valid_in && !wr_acc;
        wr_ptr_next = wr_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
        rd_ptr_next = rd_acc ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        occ_next    = occ_reg;
        if (wr_acc && !rd_acc) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (rd_acc && !wr_acc) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            empty_reg    <= 1'b1;
            ready_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            occ_reg      <= occ_next;
            empty_reg    <= (occ_next == '0);
            // Dropping ready with SLACK entries still free absorbs the flit already on the wire.
            ready_reg    <= (occ_next <= OCC_READY_MAX);
            overflow_reg <= overflow_reg | drop;
        end
    end

    rx_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (data_out)
    );

    assign ready_out = ready_reg;
    assign empty     = empty_reg;
    assign occupancy = occ_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_link_rx_buffer.sv
// Bench for link_rx_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_link_rx_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int SLACK = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          rd_en = 1'b0;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic          empty;
    logic [2:0]    occupancy;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;

    link_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .READY_SLACK(SLACK)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .occupancy (occupancy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of held flits plus the sticky and registered flags.
    logic [DW-1:0] mq [$];
    bit            m_ready = 0;
    bit            m_ovf   = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ready = 0;
            m_ovf   = 0;
        end else begin
            bit ra, wa;
            ra = rd_en && (mq.size() > 0);
            wa = valid_in && ((mq.size() < DEPTH) || ra);
            if (valid_in && !wa) m_ovf = 1;
            if (ra) void'(mq.pop_front());
            if (wa) mq.push_back(data_in);
            m_ready = (mq.size() <= DEPTH - 1 - SLACK);
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_ready", {31'd0, ready_out}, {31'd0, m_ready});
        chk("model_empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("model_occ", {29'd0, occupancy}, DW'(mq.size()));
        chk("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        if (!rst) chk("model_rst_data", data_out, '0);
        else if (mq.size() > 0) chk("model_head", data_out, mq[0]);
    end

    task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
        valid_in = v;
        data_in  = d;
        rd_en    = r;
        @(posedge clk);
        #1;
        valid_in = 0;
        rd_en    = 0;
        $display("step v=%0d d=%08h r=%0d -> occ=%0d rdy=%0d empty=%0d ovf=%0d head=%08h",
                 v, d, r, occupancy, ready_out, empty, overflow, data_out);
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_out}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_occ", {29'd0, occupancy}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        rst = 1'b1;
        step(0, 0, 0);
        chk("ready_rise", {31'd0, ready_out}, 32'd1);

        // Fill: ready falls after the 3rd write
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hA0 + i, 0);
            chk("fill_occ", {29'd0, occupancy}, 32'(i + 1));
            chk("fill_ready", {31'd0, ready_out}, (i < 2) ? 32'd1 : 32'd0);
            chk("fill_head", data_out, 32'hA0);
        end

        // Overflow from full
        step(1, 32'hA4, 0);
        chk("ovf_occ", {29'd0, occupancy}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", data_out, 32'hA0 + i);
            step(0, 0, 1);
            chk("drain_ready", {31'd0, ready_out}, (i == 0) ? 32'd0 : 32'd1);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Full pass-through
        for (int i = 0; i < 4; i++) step(1, 32'hC0 + i, 0);
        step(1, 32'hB0, 1);
        chk("pass_occ", {29'd0, occupancy}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("pass_head", data_out, (i == 3) ? 32'hB0 : 32'hC1 + i);
            step(0, 0, 1);
        end

        // Empty corners
        step(0, 0, 1);
        chk("empty_rd_occ", {29'd0, occupancy}, 32'd0);
        chk("empty_rd_empty", {31'd0, empty}, 32'd1);
        step(1, 32'hD0, 1);
        chk("empty_wr_rd_occ", {29'd0, occupancy}, 32'd1);
        chk("empty_wr_rd_head", data_out, 32'hD0);
        step(0, 0, 1);

        // Stream across pointer wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 32'hE0 + i, 1);
            chk("wrap_head", data_out, 32'hE0 + i);
            chk("wrap_occ", {29'd0, occupancy}, 32'd1);
        end
        step(1, 32'hF0, 0);
        chk("held2_occ", {29'd0, occupancy}, 32'd2);

        // Asynchronous reset mid-cycle
        #3 rst = 1'b0;
        #1;
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_ready", {31'd0, ready_out}, 32'd0);
        chk("arst_occ", {29'd0, occupancy}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            int mode;
            mode = i / 150;
            step($urandom_range(0, 99) < ((mode % 2) ? 80 : 45),
                 $urandom,
                 $urandom_range(0, 99) < ((mode % 2) ? 40 : 60));
            if (i == 300) begin
                #2 rst = 1'b0;
                #3 rst = 1'b1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
